// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin front end that shares a single 1-0-1 Moore
// sequence detector among N_REQ word-producing requesters.
//
// Handshake: a requester raises req[i] (level) with its word on data and holds
// both until it sees ack[i]. The word is captured at the edge where the
// request is granted, so later data changes and an early req drop are ignored.
// ack[i] is a one-cycle pulse, and resp_id/resp_cnt are valid only while ack
// is nonzero.
module seq_det_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1),
    parameter int TOT_W  = 16,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   data,
    output logic [N_REQ-1:0]          ack,
    output logic [ID_W-1:0]           resp_id,
    output logic [CNT_W-1:0]          resp_cnt,
    output logic                      busy,
    output logic                      det_out,
    input  logic                      clr_total,
    output logic [TOT_W-1:0]          total
);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, RESP} ctrl_e;
    typedef enum logic [1:0] {D_IDLE, S1, S10, S101} det_e;

    ctrl_e              ctrl_q, ctrl_d;
    det_e               det_q, det_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [CNT_W-1:0]   resp_cnt_q, resp_cnt_d;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic [WORD_W-1:0]  grant_word;
    logic               accept;
    logic               det_in;
    logic               match;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Select the word belonging to the requester being granted.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                grant_word = data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign accept = (ctrl_q == IDLE) && grant_valid;
    // Only real word bits reach the detector; outside SHIFT it sees zeros,
    // which can never complete a match.
    assign det_in = (ctrl_q == SHIFT) && word_q[WORD_W-1];
    // A match counts only while a word is in flight (including the flush cycle).
    assign match  = (det_q == S101) && ((ctrl_q == SHIFT) || (ctrl_q == FLUSH));

    // Controller and detector state registers, plus all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= IDLE;
            det_q      <= D_IDLE;
            ptr_q      <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            total_q    <= '0;
            ack_q      <= '0;
            resp_id_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            det_q      <= det_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            word_q     <= word_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            ack_q      <= ack_d;
            resp_id_q  <= resp_id_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    // Controller next state: IDLE -> SHIFT (WORD_W bits) -> FLUSH -> RESP -> IDLE.
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            IDLE:    if (grant_valid) ctrl_d = SHIFT;
            SHIFT:   if (bit_cnt_q == CNT_W'(WORD_W - 1)) ctrl_d = FLUSH;
            FLUSH:   ctrl_d = RESP;
            RESP:    ctrl_d = IDLE;
            default: ctrl_d = IDLE;
        endcase
    end

    // Detector next state; restarted from D_IDLE whenever a new word is accepted.
    always_comb begin
        det_d = det_q;
        if (accept) begin
            det_d = D_IDLE;
        end else begin
            case (det_q)
                D_IDLE:  det_d = det_in ? S1 : D_IDLE;
                S1:      det_d = det_in ? S1 : S10;
                S10:     det_d = det_in ? S101 : D_IDLE;
                S101:    det_d = D_IDLE;
                default: det_d = D_IDLE;
            endcase
        end
    end

    // Capture on grant, MSB-first shift, match counting and the running total.
    always_comb begin
        ptr_d     = ptr_q;
        id_d      = id_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        if (accept) begin
            ptr_d     = grant_id;
            id_d      = grant_id;
            word_d    = grant_word;
            bit_cnt_d = '0;
            cnt_d     = '0;
        end else if (ctrl_q == SHIFT) begin
            word_d    = word_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (match) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clr_total) begin
            total_d = '0;
        end else if (match && (total_q != {TOT_W{1'b1}})) begin
            total_d = total_q + 1'b1;
        end
    end

    // Response outputs are registered from RESP so they pulse for one cycle
    // and fall back to zero together with ack.
    always_comb begin
        ack_d      = '0;
        resp_id_d  = '0;
        resp_cnt_d = '0;
        if (ctrl_q == RESP) begin
            ack_d      = N_REQ'(1) << id_q;
            resp_id_d  = id_q;
            resp_cnt_d = cnt_q;
        end
    end

    assign ack      = ack_q;
    assign resp_id  = resp_id_q;
    assign resp_cnt = resp_cnt_q;
    assign busy     = (ctrl_q != IDLE);
    assign det_out  = (det_q == S101);
    assign total    = total_q;

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
- Shares one 1-0-1 Moore sequence detector among N_REQ requesters.
- Each requester posts a parallel word with a req/ack handshake. The block arbitrates round-robin, latches the granted word, and shifts it MSB-first through the internal detector.
- It returns the number of matches in that word to the requester, and keeps a saturating running total of all matches.
- Sits between word-producing clients and the serial detect datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per word.
- CNT_W, $clog2(WORD_W+1), width of the per-word match count.
- TOT_W, 16, width of the running total.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request, level.
- data  input  N_REQ*WORD_W  per-requester word; requester i uses bits [i*WORD_W +: WORD_W].
- ack  output  N_REQ  one-hot, one-cycle pulse to the served requester.
- resp_id  output  $clog2(N_REQ)  index of the served requester; valid while ack is nonzero.
- resp_cnt  output  CNT_W  match count for the served word; valid while ack is nonzero.
- busy  output  1  high in every state other than IDLE.
- det_out  output  1  Moore detector output, high while the detector is in S101.
- clr_total  input  1  synchronous clear of the running total.
- total  output  TOT_W  saturating running total of matches.

Behaviour:
- Reset (async, rst_n=0) clears all of the following:
  - ack=0, resp_id=0, resp_cnt=0, busy=0, det_out=0, total=0.
  - Controller goes to IDLE, detector goes to D_IDLE.
  - Round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
- Controller states: IDLE, SHIFT, FLUSH, RESP.
- IDLE, at an edge with any req bit high:
  - Pick the first requester with req high, searching from pointer+1 upward with wrap-around.
  - Latch its word and its id; set pointer to that id.
  - Clear bit_cnt and the per-word count; force the detector to D_IDLE.
  - Go to SHIFT.
- SHIFT:
  - Each cycle, present word[WORD_W-1-bit_cnt] to the detector and increment bit_cnt.
  - After WORD_W edges, go to FLUSH.
- FLUSH: one cycle, so a match produced by the last bit is counted. Then go to RESP.
- RESP:
  - ack[id]=1, resp_id=id, resp_cnt=count, for exactly one cycle.
  - Next state is IDLE; arbitration resumes at the next edge.
  - resp_id and resp_cnt return to 0 when ack falls.
- Detector states and transitions (det_out=1 only in S101):
  - D_IDLE: input 1 -> S1; input 0 -> D_IDLE.
  - S1: input 0 -> S10; input 1 -> S1.
  - S10: input 1 -> S101; input 0 -> D_IDLE.
  - S101: -> D_IDLE unconditionally; the bit presented in that cycle is discarded.
- Counting:
  - At every edge in SHIFT or FLUSH where the detector state is S101, increment the per-word count and the total.
  - The total saturates at 2^TOT_W-1.
  - clr_total has priority over an increment in the same cycle; total is 0 after that edge.
- Latency:
  - The request is accepted at edge E0.
  - ack is high between edges E0+WORD_W+2 and E0+WORD_W+3, i.e. 10 edges after acceptance for WORD_W=8.
  - Throughput is one word per WORD_W+3 cycles.
- Boundary conditions:
  - req dropped mid-service: service still completes and ack still pulses.
  - data changed after acceptance: ignored.
  - A requester holding req high after its ack is served again only if no other req is pending at the next IDLE edge.
  - req pulses shorter than one IDLE sample are not guaranteed to be seen; requesters hold req until ack.
  - rst_n asserted mid-operation: immediate return to reset values, no ack issued, the pending word is lost.

Test Plan:
- Reset then req=4'b0001 with data0=8'b1010_1010 -> ack[0] pulses 10 cycles after acceptance, resp_cnt=2, resp_id=0, total=2, busy high 10 cycles. The bit after each match is discarded.
- req=4'b1111 held, all words 8'b0010_1000 -> grant order 0,1,2,3,0 with each resp_cnt=1; total increments by 1 per word; no requester served twice in a row.
- data=8'b1111_1111 and 8'b0000_0000 -> resp_cnt=0 for both, det_out never high; data=8'b0000_0101 -> resp_cnt=1, proving the FLUSH cycle counts a last-bit match.
- Drop rst_n during the 5th SHIFT cycle -> all outputs 0 immediately, no ack; after release, req still high is re-served from the start with the correct count.
- Preload total to 16'hFFFF, then a word with one match -> total stays 16'hFFFF. Assert clr_total on the same cycle as a counted match -> total=0.
- Change data0 from 8'b1010_0000 to 8'b0000_0000 two cycles after acceptance -> resp_cnt=1, i.e. the latched value is used.
